// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/result bundle between the EX-stage issue logic and the
// iterative multiply/divide unit.
//   master : issue side  (drives in_*, observes out_*)
//   slave  : ex_muldiv   (observes in_*, drives out_*)
// Signals:
//   in_start  begin the operation selected by in_op
//   in_op     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   in_a      rs operand (multiplicand / dividend / mthi-mtlo data)
//   in_b      rt operand (multiplier / divisor)
//   in_mthi   write in_a to HI
//   in_mtlo   write in_a to LO
//   in_flush  abort the operation in flight
//   out_busy  operation in progress
//   out_done  one-cycle pulse after HI/LO were written by an operation
//   out_hi    HI register
//   out_lo    LO register
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             in_start;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_mthi;
    logic             in_mtlo;
    logic             in_flush;
    logic             out_busy;
    logic             out_done;
    logic [WIDTH-1:0] out_hi;
    logic [WIDTH-1:0] out_lo;

    modport master (
        output in_start, in_op, in_a, in_b, in_mthi, in_mtlo, in_flush,
        input  out_busy, out_done, out_hi, out_lo
    );

    modport slave (
        input  in_start, in_op, in_a, in_b, in_mthi, in_mtlo, in_flush,
        output out_busy, out_done, out_hi, out_lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit of the EX stage. Owns HI/LO and
// runs MULT/MULTU (shift-add) and DIV/DIVU (restoring shift-subtract) on
// magnitudes, one step per cycle for WIDTH cycles, then applies the sign
// correction in a FIX cycle and writes HI/LO.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  ex_muldiv_if.slave (start/op/operands/mthi/mtlo/flush in,
//        busy/done/HI/LO out); all outputs come straight from registers.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's-complement negate when neg is set (used for |x| and sign fix-up).
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                  input logic neg);
        return neg ? ({WIDTH{1'b0}} - x) : x;
    endfunction

    state_t               state_r;
    state_t               state_nx_s;
    logic [CW-1:0]        count_r;
    logic [2*WIDTH-1:0]   acc_r;      // mul: {partial, multiplier}; div: {rem, dividend/quotient}
    logic [WIDTH-1:0]     b_r;        // |multiplicand| or |divisor|
    logic                 sign_a_r;
    logic                 sign_b_r;
    logic [1:0]           op_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 idle_s;
    logic                 start_go_s;
    logic                 signed_op_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       div_ext_s;
    logic [WIDTH-1:0]     div_diff_s;
    logic                 div_ge_s;
    logic [2*WIDTH-1:0]   step_acc_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     res_hi_s;
    logic [WIDTH-1:0]     res_lo_s;

    assign idle_s      = (state_r == ST_IDLE) || (state_r == ST_DONE);
    assign start_go_s  = idle_s && bus.in_start && !bus.in_flush;
    assign signed_op_s = ~bus.in_op[0];

    // Next-state logic; flush wins over both start and completion.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_go_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.in_flush) begin
                    state_nx_s = ST_IDLE;
                end else if (count_r == CW'(WIDTH - 1)) begin
                    state_nx_s = ST_FIX;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_FIX: begin
                if (bus.in_flush) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        // Partial remainder shifted left with the next dividend bit; it is
        // below 2*divisor, so it needs one extra bit before the compare.
        div_ext_s  = acc_r[2*WIDTH-1:WIDTH-1];
        div_ge_s   = (div_ext_s >= {1'b0, b_r});
        div_diff_s = div_ext_s[WIDTH-1:0] - b_r;
        if (op_r[1]) begin
            if (div_ge_s) begin
                step_acc_s = {div_diff_s, acc_r[WIDTH-2:0], 1'b1};
            end else begin
                step_acc_s = {div_ext_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign correction of the magnitude result. The remainder of a divide by
    // zero equals |a|, so restoring the dividend sign yields the original a.
    always_comb begin
        prod_s   = acc_r;
        res_hi_s = acc_r[2*WIDTH-1:WIDTH];
        res_lo_s = acc_r[WIDTH-1:0];
        if (op_r[1]) begin
            res_hi_s = cond_neg(acc_r[2*WIDTH-1:WIDTH], ~op_r[0] & sign_a_r);
            if (b_r == {WIDTH{1'b0}}) begin
                res_lo_s = {WIDTH{1'b1}};
            end else begin
                res_lo_s = cond_neg(acc_r[WIDTH-1:0], ~op_r[0] & (sign_a_r ^ sign_b_r));
            end
        end else begin
            if (~op_r[0] & (sign_a_r ^ sign_b_r)) begin
                prod_s = {(2*WIDTH){1'b0}} - acc_r;
            end else begin
                prod_s = acc_r;
            end
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Operand latch and iteration datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            b_r      <= {WIDTH{1'b0}};
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            op_r     <= 2'b00;
            count_r  <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_go_s) begin
                        sign_a_r <= signed_op_s & bus.in_a[WIDTH-1];
                        sign_b_r <= signed_op_s & bus.in_b[WIDTH-1];
                        acc_r    <= {{WIDTH{1'b0}},
                                     cond_neg(bus.in_a, signed_op_s & bus.in_a[WIDTH-1])};
                        b_r      <= cond_neg(bus.in_b, signed_op_s & bus.in_b[WIDTH-1]);
                        op_r     <= bus.in_op;
                        count_r  <= {CW{1'b0}};
                    end
                end
                ST_RUN: begin
                    acc_r   <= step_acc_s;
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                end
                default: begin
                end
            endcase
        end
    end

    // HI/LO: op result in FIX (unless flushed), mthi/mtlo only while not busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if ((state_r == ST_FIX) && !bus.in_flush) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else if (idle_s) begin
            if (bus.in_mthi) begin
                hi_r <= bus.in_a;
            end
            if (bus.in_mtlo) begin
                lo_r <= bus.in_a;
            end
        end
    end

    // Registered status flags decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == ST_RUN) || (state_nx_s == ST_FIX);
            done_r <= (state_nx_s == ST_DONE);
        end
    end

    assign bus.out_busy = busy_r;
    assign bus.out_done = done_r;
    assign bus.out_hi   = hi_r;
    assign bus.out_lo   = lo_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: self-checking bench for ex_muldiv. A timeline model (remaining
// busy cycles plus an arithmetically computed pending result) predicts
// busy/done/HI/LO and is compared on every falling edge; directed cases check
// literal values, and a randomized loop exercises ops, flushes and mthi/mtlo.
module tb_ex_muldiv;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ex_muldiv_if #(.WIDTH(W)) bus ();

    ex_muldiv #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    logic         m_done;
    int           m_left;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic.
    function automatic void ref_calc(input logic [1:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic signed [W-1:0]   sa, sb;
        logic signed [2*W-1:0] sa64, sb64;
        logic [2*W-1:0]        p;
        sa = a; sb = b; sa64 = sa; sb64 = sb;
        hi = '0; lo = '0;
        case (op)
            2'b00: begin p = sa64 * sb64; hi = p[2*W-1:W]; lo = p[W-1:0]; end
            2'b01: begin p = {32'h0, a} * {32'h0, b}; hi = p[2*W-1:W]; lo = p[W-1:0]; end
            2'b10: begin
                if (b == 32'h0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 32'h0; lo = a; end
                else begin lo = sa / sb; hi = sa % sb; end
            end
            default: begin
                if (b == 32'h0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    // Compare DUT to model, then advance the model by the coming rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_hi = '0; m_lo = '0; m_done = 1'b0; m_left = 0; p_hi = '0; p_lo = '0;
            end
            check("busy", {63'h0, bus.out_busy}, {63'h0, (m_left > 0)});
            check("done", {63'h0, bus.out_done}, {63'h0, m_done});
            check("hi", {32'h0, bus.out_hi}, {32'h0, m_hi});
            check("lo", {32'h0, bus.out_lo}, {32'h0, m_lo});
            if (!rst) begin
                m_done = 1'b0;
                if (m_left > 0) begin
                    if (bus.in_flush) begin
                        m_left = 0;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                        end
                    end
                end else begin
                    if (bus.in_mthi) m_hi = bus.in_a;
                    if (bus.in_mtlo) m_lo = bus.in_a;
                    if (bus.in_start && !bus.in_flush) begin
                        ref_calc(bus.in_op, bus.in_a, bus.in_b, p_hi, p_lo);
                        m_left = W + 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_start = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
        tick();
        bus.in_start = 1'b0;
    endtask

    // Wait for out_done (bounded), check literal result, busy length and pulse width.
    task automatic wait_result(input string name, input logic [W-1:0] eh, input logic [W-1:0] el);
        int busy_n;
        bit seen;
        busy_n = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_busy) busy_n++;
            if (bus.out_done) begin seen = 1'b1; break; end
        end
        check({name, "_done_seen"}, {63'h0, seen}, 64'h1);
        check({name, "_busy_cycles"}, 64'(busy_n), 64'd33);
        check({name, "_hi"}, {32'h0, bus.out_hi}, {32'h0, eh});
        check({name, "_lo"}, {32'h0, bus.out_lo}, {32'h0, el});
        tick();
        @(negedge clk);
        check({name, "_done_one_cycle"}, {63'h0, bus.out_done}, 64'h0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rh, rl, a, b;
        logic [1:0]   op;
        bus.in_start = 1'b0; bus.in_op = 2'b00; bus.in_a = '0; bus.in_b = '0;
        bus.in_mthi = 1'b0; bus.in_mtlo = 1'b0; bus.in_flush = 1'b0;
        rst = 1'b1;
        #2;
        check("reset_hi", {32'h0, bus.out_hi}, 64'h0);
        check("reset_busy", {63'h0, bus.out_busy}, 64'h0);
        tick(); tick();
        rst = 1'b0;

        // model pins against hand-computed values
        ref_calc(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl);
        check("pin_multu", {rh, rl}, 64'hFFFF_FFFE_0000_0001);
        ref_calc(2'b00, 32'hFFFF_FFFD, 32'd7, rh, rl);
        check("pin_mult", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFEB);
        ref_calc(2'b10, 32'hFFFF_FFF9, 32'd2, rh, rl);
        check("pin_div", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFFD);
        ref_calc(2'b11, 32'h0000_1234, 32'd0, rh, rl);
        check("pin_divz", {rh, rl}, 64'h0000_1234_FFFF_FFFF);

        // directed cases
        tick();
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);         wait_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000); wait_result("mult_min", 32'h4000_0000, 32'h0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);         wait_result("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(2'b11, 32'd7, 32'd2);                 wait_result("divu_7_2", 32'd1, 32'd3);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_result("div_ovf", 32'h0, 32'h8000_0000);
        issue(2'b11, 32'h0000_1234, 32'd0);         wait_result("divu_z", 32'h0000_1234, 32'hFFFF_FFFF);
        issue(2'b10, 32'hFFFF_FF00, 32'd0);         wait_result("div_z_neg", 32'hFFFF_FF00, 32'hFFFF_FFFF);

        // mthi/mtlo, ignored start/mthi while busy, flush at count 10
        bus.in_a = 32'hAA; bus.in_mthi = 1'b1; tick();
        bus.in_mthi = 1'b0; bus.in_a = 32'hBB; bus.in_mtlo = 1'b1; tick();
        bus.in_mtlo = 1'b0;
        check("mthi", {32'h0, bus.out_hi}, 64'hAA);
        check("mtlo", {32'h0, bus.out_lo}, 64'hBB);
        issue(2'b11, 32'h1234_5678, 32'd3);
        repeat (4) tick();
        bus.in_start = 1'b1; bus.in_mthi = 1'b1; bus.in_a = 32'h55; tick();
        bus.in_start = 1'b0; bus.in_mthi = 1'b0;
        repeat (5) tick();
        bus.in_flush = 1'b1; tick();
        bus.in_flush = 1'b0;
        check("flush_busy", {63'h0, bus.out_busy}, 64'h0);
        check("flush_hi", {32'h0, bus.out_hi}, 64'hAA);
        check("flush_lo", {32'h0, bus.out_lo}, 64'hBB);
        repeat (40) tick();
        check("flush_no_done_hi", {32'h0, bus.out_hi}, 64'hAA);

        // back-to-back: second start sampled in DONE
        issue(2'b01, 32'd6, 32'd7);
        repeat (33) tick();
        check("b2b_done1", {63'h0, bus.out_done}, 64'h1);
        check("b2b_lo1", {32'h0, bus.out_lo}, 64'd42);
        issue(2'b11, 32'd100, 32'd7); wait_result("b2b_second", 32'd2, 32'd14);

        // async reset mid-RUN
        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {63'h0, bus.out_busy}, 64'h0);
        check("arst_done", {63'h0, bus.out_done}, 64'h0);
        check("arst_hi", {32'h0, bus.out_hi}, 64'h0);
        check("arst_lo", {32'h0, bus.out_lo}, 64'h0);
        tick();
        rst = 1'b0;
        repeat (40) tick();

        // randomized ops with mthi/mtlo at start and occasional flushes
        for (int n = 0; n < 50; n++) begin
            int sel;
            op = 2'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'h0;
            if (sel == 1) b = $urandom_range(1, 15);
            if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 3) a = $urandom_range(0, 255);
            bus.in_mthi = ($urandom_range(0, 3) == 0);
            bus.in_mtlo = ($urandom_range(0, 3) == 0);
            issue(op, a, b);
            bus.in_mthi = 1'b0; bus.in_mtlo = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 33)) tick();
                bus.in_flush = 1'b1; tick();
                bus.in_flush = 1'b0;
            end
            for (int i = 0; i < 50; i++) begin
                if (!bus.out_busy) break;
                tick();
            end
            check("rand_busy_timeout", {63'h0, bus.out_busy}, 64'h0);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
